// File: rtl/csr_controller_if.sv
// Bundle of the CSR-unit signals between the decoder/trap unit and the CSR file.
//   master : decoder + trap unit side (drives op, address, operands and trap info)
//   slave  : csr_controller side (returns read data, illegal flag and live CSR values)
interface csr_controller_if;
   logic [2:0]  opcode_i;        // funct3 CSR op
   logic [11:0] addr_i;          // CSR address
   logic        write_enable_i;  // CSR instruction valid this cycle
   logic [31:0] rs1_data_i;      // register operand
   logic [31:0] imm_data_i;      // zero-extended zimm
   logic [31:0] pc_i;            // PC of current instruction
   logic        trap_i;          // trap taken this cycle
   logic [31:0] mcause_i;        // cause for the trap
   logic [31:0] read_data_o;     // pre-write value of addressed CSR
   logic        illegal_o;       // bad op or unimplemented address
   logic [31:0] mie_o;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;

   modport master (
      output opcode_i, addr_i, write_enable_i, rs1_data_i, imm_data_i, pc_i, trap_i,
             mcause_i,
      input  read_data_o, illegal_o, mie_o, mtvec_o, mepc_o
   );

   modport slave (
      input  opcode_i, addr_i, write_enable_i, rs1_data_i, imm_data_i, pc_i, trap_i,
             mcause_i,
      output read_data_o, illegal_o, mie_o, mtvec_o, mepc_o
   );
endinterface

// File: rtl/csr_controller.sv
// Machine-mode CSR file: mie, mtvec, mscratch, mepc, mcause with Zicsr read-modify-write.
// On a trap, captures the PC into mepc and the cause into mcause; CSR writes in that cycle
// are dropped because the trapping instruction does not retire.
// Ports:
//   clk_i   : clock, all state updates on rising edge
//   rst_ni  : asynchronous active-low reset
//   csr_io  : csr_controller_if.slave (op/addr/operands/trap in; read data, illegal,
//             mie/mtvec/mepc out)
module csr_controller #(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter logic [31:0] MIE_WMASK = 32'hFFFF_FFFF
) (
   input logic              clk_i,
   input logic              rst_ni,
   csr_controller_if.slave  csr_io
);

   localparam logic [11:0] MieAddr      = 12'h304;
   localparam logic [11:0] MtvecAddr    = 12'h305;
   localparam logic [11:0] MscratchAddr = 12'h340;
   localparam logic [11:0] MepcAddr     = 12'h341;
   localparam logic [11:0] McauseAddr   = 12'h342;

   localparam logic [31:0] AlignMask    = 32'hFFFF_FFFC;
   localparam logic [31:0] MtvecRstVal  = MTVEC_RST & AlignMask;

   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;

   logic [31:0] old_val;
   logic [31:0] src;
   logic [31:0] new_val;
   logic        addr_hit;
   logic        op_legal;
   logic        commit;

   // Read mux: pre-write value, independent of write_enable_i.
   always_comb begin
      old_val  = 32'h0;
      addr_hit = 1'b1;
      unique case (csr_io.addr_i)
         MieAddr:      old_val = mie_q;
         MtvecAddr:    old_val = mtvec_q;
         MscratchAddr: old_val = mscratch_q;
         MepcAddr:     old_val = mepc_q;
         McauseAddr:   old_val = mcause_q;
         default:      addr_hit = 1'b0;
      endcase
   end

   // funct3[1:0]==0 (000 / 100) is not a CSR op.
   assign op_legal = (csr_io.opcode_i[1:0] != 2'b00);
   assign src      = csr_io.opcode_i[2] ? csr_io.imm_data_i : csr_io.rs1_data_i;
   assign commit   = csr_io.write_enable_i & op_legal & addr_hit & ~csr_io.trap_i;

   always_comb begin
      new_val = old_val;
      unique case (csr_io.opcode_i[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = old_val | src;
         2'b11:   new_val = old_val & ~src;
         default: new_val = old_val;
      endcase
   end

   always_comb begin
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (commit) begin
         unique case (csr_io.addr_i)
            MieAddr:      mie_d      = new_val & MIE_WMASK;
            MtvecAddr:    mtvec_d    = new_val & AlignMask;
            MscratchAddr: mscratch_d = new_val;
            MepcAddr:     mepc_d     = new_val & AlignMask;
            McauseAddr:   mcause_d   = new_val;
            default:      ;
         endcase
      end
      // Trap capture overrides; commit is already blocked when trap_i is high.
      if (csr_io.trap_i) begin
         mepc_d   = csr_io.pc_i & AlignMask;
         mcause_d = csr_io.mcause_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mie_q      <= 32'h0;
         mtvec_q    <= MtvecRstVal;
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mcause_q   <= 32'h0;
      end else begin
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   assign csr_io.read_data_o = old_val;
   assign csr_io.illegal_o   = csr_io.write_enable_i & (~op_legal | ~addr_hit);
   assign csr_io.mie_o       = mie_q;
   assign csr_io.mtvec_o     = mtvec_q;
   assign csr_io.mepc_o      = mepc_q;

endmodule

// File: tb/tb_csr_controller.sv
module tb_csr_controller;

   localparam logic [2:0] OpRw  = 3'b001;
   localparam logic [2:0] OpRs  = 3'b010;
   localparam logic [2:0] OpRc  = 3'b011;
   localparam logic [2:0] OpRwi = 3'b101;
   localparam logic [2:0] OpRsi = 3'b110;
   localparam logic [2:0] OpRci = 3'b111;

   localparam logic [11:0] AMie      = 12'h304;
   localparam logic [11:0] AMtvec    = 12'h305;
   localparam logic [11:0] AMscratch = 12'h340;
   localparam logic [11:0] AMepc     = 12'h341;
   localparam logic [11:0] AMcause   = 12'h342;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   csr_controller_if bus ();

   csr_controller #(
      .MTVEC_RST (32'h0000_0103),
      .MIE_WMASK (32'h0000_0888)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .csr_io (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [31:0] imm);
      bus.write_enable_i = we;
      bus.opcode_i       = op;
      bus.addr_i         = addr;
      bus.rs1_data_i     = rs1;
      bus.imm_data_i     = imm;
   endtask

   task automatic read_at(input logic [11:0] addr);
      drive(1'b0, 3'b000, addr, 32'h0, 32'h0);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      drive(1'b0, 3'b000, 12'h000, 32'h0, 32'h0);
      bus.pc_i     = 32'h0;
      bus.trap_i   = 1'b0;
      bus.mcause_i = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      read_at(AMcause);
      check("rst_mtvec", bus.mtvec_o, 32'h0000_0100);
      check("rst_mie", bus.mie_o, 32'h0);
      check("rst_mepc", bus.mepc_o, 32'h0);
      check("rst_mcause", bus.read_data_o, 32'h0);
      check("rst_illegal", {31'b0, bus.illegal_o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // mscratch RW / RS / RCI chain, back-to-back
      @(negedge clk);
      drive(1'b1, OpRw, AMscratch, 32'hDEAD_BEEF, 32'h0);
      #1;
      check("rw_old", bus.read_data_o, 32'h0);
      check("rw_legal", {31'b0, bus.illegal_o}, 32'h0);
      @(negedge clk);
      drive(1'b1, OpRs, AMscratch, 32'h0000_0010, 32'h0);
      #1;
      check("rw_new", bus.read_data_o, 32'hDEAD_BEEF);
      @(negedge clk);
      drive(1'b1, OpRci, AMscratch, 32'hFFFF_FFFF, 32'h0000_000F);
      #1;
      check("rs_new", bus.read_data_o, 32'hDEAD_BEFF);
      @(negedge clk);
      read_at(AMscratch);
      check("rci_new", bus.read_data_o, 32'hDEAD_BEF0);

      // mie write through writable mask
      drive(1'b1, OpRwi, AMie, 32'h0, 32'h0000_001F);
      @(negedge clk);
      read_at(AMie);
      check("mie_out", bus.mie_o, 32'h0000_0008);
      check("mie_rd", bus.read_data_o, 32'h0000_0008);

      // mtvec low bits forced to zero
      drive(1'b1, OpRw, AMtvec, 32'h1234_5677, 32'h0);
      @(negedge clk);
      #1;
      check("mtvec_align", bus.mtvec_o, 32'h1234_5674);

      // mepc alignment, back-to-back clear, zero-source set keeps value
      drive(1'b1, OpRw, AMepc, 32'h0000_0FFF, 32'h0);
      @(negedge clk);
      drive(1'b1, OpRc, AMepc, 32'h0000_000C, 32'h0);
      #1;
      check("mepc_align", bus.mepc_o, 32'h0000_0FFC);
      @(negedge clk);
      drive(1'b1, OpRsi, AMepc, 32'h0, 32'h0);
      #1;
      check("mepc_clr", bus.mepc_o, 32'h0000_0FF0);
      @(negedge clk);
      #1;
      check("mepc_rs0", bus.mepc_o, 32'h0000_0FF0);

      // Trap with concurrent mscratch write: write suppressed
      drive(1'b1, OpRw, AMscratch, 32'h0000_0001, 32'h0);
      bus.trap_i   = 1'b1;
      bus.pc_i     = 32'h0000_1236;
      bus.mcause_i = 32'h8000_000B;
      #1;
      check("trap_mtvec", bus.mtvec_o, 32'h1234_5674);
      @(negedge clk);
      bus.trap_i = 1'b0;
      read_at(AMcause);
      check("trap_mepc", bus.mepc_o, 32'h0000_1234);
      check("trap_mcause", bus.read_data_o, 32'h8000_000B);
      read_at(AMscratch);
      check("trap_mscr", bus.read_data_o, 32'hDEAD_BEF0);

      // Illegal: unimplemented address
      drive(1'b1, OpRw, 12'h300, 32'hFFFF_FFFF, 32'h0);
      #1;
      check("ill_addr", {31'b0, bus.illegal_o}, 32'h1);
      check("ill_addr_rd", bus.read_data_o, 32'h0);
      @(negedge clk);
      // Illegal: opcode 100
      drive(1'b1, 3'b100, AMscratch, 32'h0, 32'h0000_001F);
      #1;
      check("ill_op", {31'b0, bus.illegal_o}, 32'h1);
      check("ill_op_rd", bus.read_data_o, 32'hDEAD_BEF0);
      @(negedge clk);
      read_at(AMscratch);
      check("ill_mscr", bus.read_data_o, 32'hDEAD_BEF0);
      check("ill_mie", bus.mie_o, 32'h0000_0008);
      check("ill_mtvec", bus.mtvec_o, 32'h1234_5674);
      check("ill_mepc", bus.mepc_o, 32'h0000_1234);

      // Async reset mid-cycle with a write pending
      drive(1'b1, OpRw, AMscratch, 32'h5555_5555, 32'h0);
      @(posedge clk);
      #2;
      drive(1'b1, OpRw, AMscratch, 32'hAAAA_AAAA, 32'h0);
      rst_n = 1'b0;
      #1;
      check("arst_mscr", bus.read_data_o, 32'h0);
      check("arst_mie", bus.mie_o, 32'h0);
      check("arst_mepc", bus.mepc_o, 32'h0);
      check("arst_mtvec", bus.mtvec_o, 32'h0000_0100);
      @(posedge clk);
      #1;
      check("arst_hold", bus.read_data_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_at(AMscratch);
      check("arst_resume", bus.read_data_o, 32'hAAAA_AAAA);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
